// File: rtl/pipeline_ctrl.sv
`default_nettype none
// pipeline_ctrl: pipeline enable/bubble/flush sequencing, PC redirect and exception FSM.
// Revision 1.0 - initial release
module pipeline_ctrl #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  HANDLER_PC = 32'h0000_2000,
  parameter int               EXCPT_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_req,
  input  logic [EXCPT_W-1:0] excpt_in,
  input  logic [XLEN-1:0]    excpt_pc,
  input  logic [XLEN-1:0]    excpt_addr,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               eret,
  input  logic               mem_busy,
  output logic               pc_we,
  output logic               if_id_we,
  output logic               id_ex_bubble,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    epc,
  output logic [EXCPT_W-1:0] cause,
  output logic [XLEN-1:0]    bad_addr,
  output logic               in_handler,
  output logic               halted
);

  localparam logic [EXCPT_W-1:0] EXC_UNALIGNED = EXCPT_W'(1);
  localparam logic [EXCPT_W-1:0] EXC_DIV0      = EXCPT_W'(2);
  localparam logic [EXCPT_W-1:0] CAUSE_ILLEGAL = '1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_HANDLER = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t state, next_state;

  logic               take_excpt;
  logic               set_in_handler;
  logic               clr_in_handler;
  logic               set_halted;
  logic               has_excpt;
  logic [EXCPT_W-1:0] excpt_cause;

  assign has_excpt   = (excpt_in != '0);
  // Reserved codes collapse onto a single "illegal" cause.
  assign excpt_cause = ((excpt_in == EXC_UNALIGNED) || (excpt_in == EXC_DIV0)) ? excpt_in : CAUSE_ILLEGAL;

  always_comb begin
    next_state     = state;
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    id_ex_bubble   = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    take_excpt     = 1'b0;
    set_in_handler = 1'b0;
    clr_in_handler = 1'b0;
    set_halted     = 1'b0;

    if (!rst_n) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (state == S_HALT) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (mem_busy) begin
      // Freeze: everything else waits until memory is ready again.
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else begin
      case (state)
        S_FLUSH: begin
          redirect_valid = 1'b1;
          redirect_pc    = HANDLER_PC;
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          set_in_handler = 1'b1;
          next_state     = S_HANDLER;
        end
        S_RUN, S_HANDLER: begin
          if (has_excpt) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            if (state == S_RUN) begin
              take_excpt = 1'b1;
              next_state = S_FLUSH;
            end else begin
              set_halted = 1'b1;
              next_state = S_HALT;
            end
          end else if (eret && (state == S_HANDLER)) begin
            redirect_valid = 1'b1;
            redirect_pc    = epc + XLEN'(4);
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            clr_in_handler = 1'b1;
            next_state     = S_RUN;
          end else if (branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = branch_target;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
          end else if (stall_req) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      epc        <= '0;
      cause      <= '0;
      bad_addr   <= '0;
      in_handler <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state <= next_state;
      if (take_excpt) begin
        epc      <= excpt_pc;
        cause    <= excpt_cause;
        bad_addr <= (excpt_in == EXC_DIV0) ? '0 : excpt_addr;
      end
      if (set_in_handler) begin
        in_handler <= 1'b1;
      end else if (clr_in_handler) begin
        in_handler <= 1'b0;
      end
      if (set_halted) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl.
// Revision 1.0 - initial release
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req;
  logic [2:0]  excpt_in;
  logic [31:0] excpt_pc;
  logic [31:0] excpt_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        eret;
  logic        mem_busy;
  logic        pc_we, if_id_we, id_ex_bubble;
  logic        flush_if_id, flush_id_ex, flush_ex_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc, epc, bad_addr;
  logic [2:0]  cause;
  logic        in_handler, halted;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .excpt_in(excpt_in),
    .excpt_pc(excpt_pc), .excpt_addr(excpt_addr), .branch_taken(branch_taken),
    .branch_target(branch_target), .eret(eret), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .epc(epc),
    .cause(cause), .bad_addr(bad_addr), .in_handler(in_handler), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PCW = 7'h40, IFW = 7'h20, BUB = 7'h10, FI = 7'h08;
  localparam logic [6:0] FD = 7'h04, FE = 7'h02, RV = 7'h01, ALL = 7'h7F;
  localparam logic [6:0] NRM = PCW | IFW;
  localparam logic [6:0] FL3 = FI | FD | FE;
  localparam logic [6:0] RDR = PCW | FI | FD | RV;
  localparam logic [6:0] M_EV = ALL & ~IFW;
  localparam logic [6:0] M_DF = ALL & ~(IFW | PCW);

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [6:0]  mask;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic [31:0] bad;
    logic        inh;
    logic        halt;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    tests = 0;
  int    failures = 0;

  logic [31:0] m_epc, m_bad;
  logic [2:0]  m_cause;
  logic        m_inh, m_halt;

  logic [6:0] obs_ctrl;
  assign obs_ctrl = {pc_we, if_id_we, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, redirect_valid};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for this cycle, compare once outputs settle, advance to next negedge.
  task automatic cyc(string tag, logic [6:0] ctrl, logic [6:0] mask, logic [31:0] rpc);
    exp_t  e;
    exp_t  g;
    string t;
    e.ctrl = ctrl; e.mask = mask; e.rpc = rpc;
    e.epc = m_epc; e.cause = m_cause; e.bad = m_bad; e.inh = m_inh; e.halt = m_halt;
    sbq.push_back(e);
    tagq.push_back(tag);
    #2;
    g = sbq.pop_front();
    t = tagq.pop_front();
    chk({t, "/ctrl"}, 32'(obs_ctrl & g.mask), 32'(g.ctrl & g.mask));
    if (g.ctrl[0]) chk({t, "/rpc"}, redirect_pc, g.rpc);
    chk({t, "/epc"}, epc, g.epc);
    chk({t, "/cause"}, 32'(cause), 32'(g.cause));
    chk({t, "/bad"}, bad_addr, g.bad);
    chk({t, "/inh"}, 32'(in_handler), 32'(g.inh));
    chk({t, "/halt"}, 32'(halted), 32'(g.halt));
    @(negedge clk);
  endtask

  task automatic idle_in();
    stall_req = 0; excpt_in = 0; excpt_pc = 0; excpt_addr = 0;
    branch_taken = 0; branch_target = 0; eret = 0; mem_busy = 0;
  endtask

  task automatic clr_model();
    m_epc = 0; m_cause = 0; m_bad = 0; m_inh = 0; m_halt = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    clr_model();
    @(negedge clk);
    cyc("reset", 7'h00, ALL, 0);
    rst_n = 1;
    cyc("idle0", NRM, ALL, 0);
    cyc("idle1", NRM, ALL, 0);

    stall_req = 1;
    cyc("stall0", BUB, ALL, 0);
    cyc("stall1", BUB, ALL, 0);
    stall_req = 0;
    cyc("post_stall", NRM, ALL, 0);

    // Exception into handler, then eret back.
    excpt_in = 1; excpt_pc = 32'h100; excpt_addr = 32'h203;
    cyc("exc1", FL3, M_EV, 0);
    idle_in();
    m_epc = 32'h100; m_cause = 1; m_bad = 32'h203;
    cyc("flush1", RDR, M_EV, 32'h2000);
    m_inh = 1;
    cyc("hnd_idle", NRM, ALL, 0);
    branch_taken = 1; branch_target = 32'h3000; stall_req = 1;
    cyc("hnd_branch", RDR, M_EV, 32'h3000);
    idle_in(); eret = 1;
    cyc("eret", RDR, M_EV, 32'h104);
    idle_in();
    m_inh = 0;
    cyc("run_after_eret", NRM, ALL, 0);
    eret = 1;
    cyc("eret_in_run", NRM, ALL, 0);
    idle_in(); branch_taken = 1; branch_target = 32'h400;
    cyc("run_branch", RDR, M_EV, 32'h400);
    idle_in();

    // Double fault.
    excpt_in = 1; excpt_pc = 32'h100; excpt_addr = 32'h203;
    cyc("exc2", FL3, M_EV, 0);
    idle_in();
    cyc("flush2", RDR, M_EV, 32'h2000);
    m_inh = 1;
    excpt_in = 2; excpt_pc = 32'h500; excpt_addr = 32'h600;
    cyc("dbl_fault", FL3, M_DF, 0);
    idle_in();
    m_halt = 1;
    for (int i = 0; i < 10; i++) begin
      branch_taken = i[0]; mem_busy = i[1]; eret = i[2]; stall_req = 1;
      branch_target = 32'h777;
      cyc("halt", FL3, ALL, 0);
    end
    idle_in();
    rst_n = 0;
    clr_model();
    cyc("halt_reset", 7'h00, ALL, 0);
    rst_n = 1;
    cyc("after_halt_reset", NRM, ALL, 0);

    // Exception beats coincident branch and stall; DIVIDE_BY_ZERO clears bad_addr.
    excpt_in = 2; excpt_pc = 32'h900; excpt_addr = 32'h904;
    branch_taken = 1; branch_target = 32'h777; stall_req = 1;
    cyc("exc_vs_branch", FL3, M_EV, 0);
    idle_in();
    m_epc = 32'h900; m_cause = 2; m_bad = 0;
    cyc("flush3", RDR, M_EV, 32'h2000);
    m_inh = 1;
    eret = 1;
    cyc("eret3", RDR, M_EV, 32'h904);
    idle_in();
    m_inh = 0;

    // mem_busy holds everything, including a pending exception.
    excpt_in = 2; excpt_pc = 32'hA00; excpt_addr = 32'hA04;
    branch_taken = 1; branch_target = 32'h777; stall_req = 1; mem_busy = 1;
    cyc("busy0", 7'h00, ALL, 0);
    cyc("busy1", 7'h00, ALL, 0);
    mem_busy = 0;
    cyc("busy_release", FL3, M_EV, 0);
    idle_in();
    m_epc = 32'hA00; m_cause = 2; m_bad = 0;
    mem_busy = 1;
    cyc("busy_in_flush", 7'h00, ALL, 0);
    mem_busy = 0;
    cyc("flush4", RDR, M_EV, 32'h2000);
    m_inh = 1;
    eret = 1;
    cyc("eret4", RDR, M_EV, 32'hA04);
    idle_in();
    m_inh = 0;

    // Reserved code maps to 7; epc+4 wraps.
    excpt_in = 5; excpt_pc = 32'hFFFF_FFFC; excpt_addr = 32'h1234;
    cyc("exc_rsvd", FL3, M_EV, 0);
    idle_in();
    m_epc = 32'hFFFF_FFFC; m_cause = 7; m_bad = 32'h1234;
    cyc("flush5", RDR, M_EV, 32'h2000);
    m_inh = 1;
    eret = 1;
    cyc("eret_wrap", RDR, M_EV, 32'h0);
    idle_in();
    m_inh = 0;

    // Reset in the middle of FLUSH.
    excpt_in = 1; excpt_pc = 32'h40; excpt_addr = 32'h41;
    cyc("exc6", FL3, M_EV, 0);
    idle_in();
    rst_n = 0;
    clr_model();
    cyc("reset_mid_flush", 7'h00, ALL, 0);
    rst_n = 1;
    cyc("run_after_reset", NRM, ALL, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
